ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- Upstream stage of the MZ-80A keyboard matrix emulator.
- Receives raw PS/2 device-to-host frames on ps2_clk/ps2_data and filters and synchronises the lines.
- Checks frame framing and odd parity, then strips the E0/F0/E1 prefix bytes.
- Emits one strobed key event per make or break: base scancode, extended flag and release flag. The matrix stage consumes these events directly.

Parameters:
- FILTER_LEN, 8: consecutive clk cycles a synchronised ps2_clk level must hold before the filtered clock changes (range 2..255).
- TIMEOUT_CYCLES, 100000: clk cycles allowed between filtered ps2_clk falling edges inside a frame before the frame is aborted. 2 ms at 50 MHz.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-high reset. Clears all state.
- ps2_clk, input, 1: raw PS/2 clock from the pad. Asynchronous to clk.
- ps2_data, input, 1: raw PS/2 data from the pad. Asynchronous to clk.
- key_valid, output, 1: one-cycle strobe marking a new key event.
- key_code, output, 8: base scancode of the last event. Held between strobes.
- key_ext, output, 1: last event was E0-prefixed. Held.
- key_release, output, 1: last event was a break (F0-prefixed). Held.
- rx_error, output, 1: one-cycle strobe on a parity, start-bit, stop-bit or timeout error.

Behaviour:
- Reset values: key_valid 0, key_code 8'h00, key_ext 0, key_release 0, rx_error 0. Receiver state IDLE. Prefix flags and skip counter cleared. Filtered clock 1.
- Synchroniser: 2-FF chains on ps2_clk and ps2_data.
- Filter: the filtered clock takes the new synchronised level only after FILTER_LEN consecutive equal samples. Any shorter pulse is ignored.
- Falling edge: the cycle in which the filtered clock goes 1→0. Data is sampled from the synchronised ps2_data in that cycle.
- Frame: 11 bits, all sampled on falling edges:
  - start = 0
  - 8 data bits, LSB first
  - odd parity
  - stop = 1
- Receiver FSM:
  - IDLE: a falling edge with data = 0 goes to DATA with bit count 0. A falling edge with data = 1 raises an rx_error pulse and stays in IDLE.
  - DATA: shift data in on each edge. After the 8th bit go to PARITY.
  - PARITY: store the parity bit, then go to STOP.
  - STOP: on the edge, if stop = 1 and the XOR of the 8 data bits and the parity bit is 1, assert byte_rdy (internal) for one cycle. Otherwise pulse rx_error. Return to IDLE in both cases.
- Timeout: the counter runs only outside IDLE and clears on every falling edge.
  - When it reaches TIMEOUT_CYCLES: return to IDLE, pulse rx_error, clear the prefix flags.
  - If the timeout and an edge occur in the same cycle, the edge wins.
- Any rx_error clears the E0/F0 prefix flags. It does not clear the skip counter.
- Decoder, on byte_rdy, evaluated in this priority order:
  1. Skip counter ≠ 0: decrement it and discard the byte.
  2. E1: skip counter := 7, clear prefixes, no event. This discards the Pause sequence.
  3. E0: set ext_pend.
  4. F0: set rel_pend.
  5. No prefix pending and byte ∈ {00, AA, EE, FA, FC, FD, FE, FF}: discard (device responses).
  6. Otherwise: key_code := byte, key_ext := ext_pend, key_release := rel_pend, key_valid := 1 for one cycle, then clear both pend flags.
- Latency: key_valid is high exactly 2 clk cycles after the filtered falling edge that samples the stop bit. rx_error follows the same timing for stop-bit faults.
- Back-to-back frames: no gap is required beyond the PS/2 protocol minimum. The decoder accepts one byte per byte_rdy.
- Async reset mid-frame: the partial frame is lost. The first complete frame after reset deasserts is decoded normally.

Test Plan:
- Frame 1C (parity 0) at a 12.5 kHz PS/2 clock → one key_valid pulse; key_code=1C, key_ext=0, key_release=0; no rx_error.
- Sequence F0 1C → exactly one key_valid (on the second byte), key_code=1C, key_release=1, key_ext=0. The next plain 32 gives key_code=32, key_release=0.
- Sequence E0 F0 75 → one key_valid, key_code=75, key_ext=1, key_release=1.
- Frame 1C with parity bit forced to 1 → rx_error pulse, no key_valid. A following clean 1C decodes normally. F0 then a bad-parity byte then 1C → key_release=0.
- Abort: 5 bits of a frame, then ps2_clk held high for TIMEOUT_CYCLES+10 → one rx_error pulse, FSM in IDLE. A following clean 32 → key_code=32.
- Discard and glitch: E1 14 77 E1 F0 14 F0 77 → no key_valid. Then AA → no key_valid. A ps2_clk low glitch of FILTER_LEN−1 cycles mid-frame → ignored, and the frame still decodes correctly. Async reset asserted mid-frame → all outputs 0 on the next sample.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Receives PS/2 device-to-host frames, validates framing and odd parity,
//   strips E0/F0/E1 prefixes and emits one strobed key event per make/break.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   ps2_clk      raw PS/2 clock pad (async)
//   ps2_data     raw PS/2 data pad (async)
//   key_valid    one-cycle strobe: new key event
//   key_code     base scancode of last event (held)
//   key_ext      last event was E0-prefixed (held)
//   key_release  last event was a break (held)
//   rx_error     one-cycle strobe on parity/start/stop/timeout error
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       rx_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic            filt_clk;
  logic [7:0]      filt_cnt;
  logic            fall;
  rx_state_t       state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par;
  logic [TW-1:0]   to_cnt;
  logic            byte_rdy;
  logic            err_int;
  logic            ext_pend, rel_pend;
  logic [2:0]      skip_cnt;

  // Two-flop synchronisers; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // filt_cnt counts consecutive samples differing from filt_clk; the
  // FILTER_LEN-th such sample commits the new level.
  wire filt_commit = (clk_s2 != filt_clk) && (filt_cnt == 8'(FILTER_LEN - 1));
  assign fall = filt_commit && filt_clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_commit) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 8'd1;
    end
  end

  // Frame receiver; an edge takes precedence over a simultaneous timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      to_cnt   <= '0;
      byte_rdy <= 1'b0;
      err_int  <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      err_int  <= 1'b0;
      if (state == S_IDLE || fall)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;

      if (fall) begin
        unique case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end else begin
              err_int <= 1'b1;
            end
          end
          S_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par   <= dat_s2;
            state <= S_STOP;
          end
          S_STOP: begin
            if (dat_s2 && ((^shreg) ^ par))
              byte_rdy <= 1'b1;
            else
              err_int <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE && to_cnt == TW'(TIMEOUT_CYCLES)) begin
        state   <= S_IDLE;
        err_int <= 1'b1;
        to_cnt  <= '0;
      end
    end
  end

  // Prefix decoder and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      rx_error    <= 1'b0;
      ext_pend    <= 1'b0;
      rel_pend    <= 1'b0;
      skip_cnt    <= '0;
    end else begin
      key_valid <= 1'b0;
      rx_error  <= err_int;
      if (err_int) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (byte_rdy) begin
        if (skip_cnt != 3'd0) begin
          skip_cnt <= skip_cnt - 3'd1;
        end else if (shreg == 8'hE1) begin
          skip_cnt <= 3'd7;
          ext_pend <= 1'b0;
          rel_pend <= 1'b0;
        end else if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          rel_pend <= 1'b1;
        end else if (!ext_pend && !rel_pend &&
                     (shreg == 8'h00 || shreg == 8'hAA || shreg == 8'hEE ||
                      shreg == 8'hFA || shreg == 8'hFC || shreg == 8'hFD ||
                      shreg == 8'hFE || shreg == 8'hFF)) begin
          // device response bytes: no key event
        end else begin
          key_code    <= shreg;
          key_ext     <= ext_pend;
          key_release <= rel_pend;
          key_valid   <= 1'b1;
          ext_pend    <= 1'b0;
          rel_pend    <= 1'b0;
        end
      end
    end
  end

endmodule
